// File: rtl/traffic_pkg.sv
// Shared encodings and phase-table helpers for the traffic light bus monitor.
// Lamp vectors are {R,Y,G}; phases P1..P6 are coded 0..5, 7 means not yet known.
package traffic_pkg;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] YEL   = 3'b010;
    localparam logic [2:0] GRN   = 3'b001;

    localparam logic [2:0] P1    = 3'd0;
    localparam logic [2:0] P2    = 3'd1;
    localparam logic [2:0] P3    = 3'd2;
    localparam logic [2:0] P4    = 3'd3;
    localparam logic [2:0] P5    = 3'd4;
    localparam logic [2:0] P6    = 3'd5;
    localparam logic [2:0] P_UNK = 3'd7;

    localparam logic [3:0] DWELL_MAX = 4'd15;

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } mon_state_e;

    function automatic logic [2:0] successor(input logic [2:0] ph);
        case (ph)
            P1:      successor = P2;
            P2:      successor = P3;
            P3:      successor = P4;
            P4:      successor = P5;
            P5:      successor = P6;
            P6:      successor = P1;
            default: successor = P_UNK;
        endcase
    endfunction

    // Yellow phases share one dwell; P_UNK never reaches a dwell check.
    function automatic logic [3:0] dwell_limit(input logic [2:0] ph,
                                               input logic [3:0] d_main,
                                               input logic [3:0] d_yel,
                                               input logic [3:0] d_turn,
                                               input logic [3:0] d_side);
        case (ph)
            P1:         dwell_limit = d_main;
            P2, P4, P6: dwell_limit = d_yel;
            P3:         dwell_limit = d_turn;
            P5:         dwell_limit = d_side;
            default:    dwell_limit = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/light_phase_decode.sv
// Combinational lamp-vector decoder: maps the four approach vectors onto a phase.
// Any combination outside the phase table (including non-one-hot lamps) is illegal.
module light_phase_decode
    import traffic_pkg::*;
(
    input  logic [2:0] m1,
    input  logic [2:0] m2,
    input  logic [2:0] mt,
    input  logic [2:0] s,
    output logic [2:0] phase,
    output logic       legal
);

    // Table lookup on the full 12-bit lamp pattern.
    always_comb begin
        phase = P_UNK;
        legal = 1'b0;
        case ({m1, m2, mt, s})
            {GRN, GRN, RED, RED}: begin phase = P1; legal = 1'b1; end
            {GRN, YEL, RED, RED}: begin phase = P2; legal = 1'b1; end
            {GRN, RED, GRN, RED}: begin phase = P3; legal = 1'b1; end
            {YEL, RED, YEL, RED}: begin phase = P4; legal = 1'b1; end
            {RED, RED, RED, GRN}: begin phase = P5; legal = 1'b1; end
            {RED, RED, RED, YEL}: begin phase = P6; legal = 1'b1; end
            default:              begin phase = P_UNK; legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Independent safety observer for the 4-approach traffic light bus.
// Tracks phase order and dwell, raises sticky fault flags and counts clean signal cycles.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int T_MAIN = 7,
    parameter int T_YEL  = 2,
    parameter int T_TURN = 5,
    parameter int T_SIDE = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       M1,
    input  logic [2:0]       M2,
    input  logic [2:0]       MT,
    input  logic [2:0]       S,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic             synced,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_timing,
    output logic             err_pulse,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [3:0] D_MAIN = 4'(T_MAIN + 1);
    localparam logic [3:0] D_YEL  = 4'(T_YEL + 1);
    localparam logic [3:0] D_TURN = 4'(T_TURN + 1);
    localparam logic [3:0] D_SIDE = 4'(T_SIDE + 1);

    logic [2:0]       dec_phase_s;
    logic             dec_legal_s;

    mon_state_e       state_r, state_s;
    logic [2:0]       phase_r, phase_s;
    logic [3:0]       dwell_r, dwell_s, dwell_inc_s, dwell_lim_s;
    logic             ovr_done_r, ovr_done_s;
    logic             synced_r;
    logic             err_illegal_r, err_seq_r, err_timing_r, err_pulse_r;
    logic             det_illegal_s, det_seq_s, det_timing_s, cnt_inc_s;
    logic [CNT_W-1:0] cycle_cnt_r;

    light_phase_decode u_decode (
        .m1    (M1),
        .m2    (M2),
        .mt    (MT),
        .s     (S),
        .phase (dec_phase_s),
        .legal (dec_legal_s)
    );

    // Next-state, dwell bookkeeping and error detection for the sampled lamp pattern.
    always_comb begin
        state_s       = state_r;
        phase_s       = phase_r;
        dwell_s       = dwell_r;
        ovr_done_s    = ovr_done_r;
        det_illegal_s = 1'b0;
        det_seq_s     = 1'b0;
        det_timing_s  = 1'b0;
        cnt_inc_s     = 1'b0;
        dwell_inc_s   = (dwell_r == DWELL_MAX) ? dwell_r : dwell_r + 4'd1;
        dwell_lim_s   = dwell_limit(phase_r, D_MAIN, D_YEL, D_TURN, D_SIDE);

        if (!dec_legal_s) begin
            det_illegal_s = 1'b1;
            state_s       = SYNC;
            phase_s       = P_UNK;
            dwell_s       = 4'd0;
            ovr_done_s    = 1'b0;
        end else begin
            case (state_r)
                SYNC: begin
                    if (phase_r == P_UNK) begin
                        phase_s    = dec_phase_s;
                        dwell_s    = 4'd1;
                        ovr_done_s = 1'b0;
                    end else if (dec_phase_s == phase_r) begin
                        dwell_s = dwell_inc_s;
                    end else begin
                        // Lock-on transition: the old occupancy was only partially seen.
                        state_s    = TRACK;
                        phase_s    = dec_phase_s;
                        dwell_s    = 4'd1;
                        ovr_done_s = 1'b0;
                    end
                end
                TRACK: begin
                    if (dec_phase_s == phase_r) begin
                        dwell_s = dwell_inc_s;
                        if ((dwell_r >= dwell_lim_s) && !ovr_done_r) begin
                            det_timing_s = 1'b1;
                            ovr_done_s   = 1'b1;
                        end else begin
                            ovr_done_s = ovr_done_r;
                        end
                    end else begin
                        if (dec_phase_s != successor(phase_r)) begin
                            det_seq_s = 1'b1;
                        end else if (dwell_r < dwell_lim_s) begin
                            det_timing_s = 1'b1;
                        end else begin
                            cnt_inc_s = (phase_r == P6);
                        end
                        phase_s    = dec_phase_s;
                        dwell_s    = 4'd1;
                        ovr_done_s = 1'b0;
                    end
                end
                default: begin
                    state_s    = SYNC;
                    phase_s    = P_UNK;
                    dwell_s    = 4'd0;
                    ovr_done_s = 1'b0;
                end
            endcase
        end
    end

    // State, sticky flags, pulse and cycle counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= SYNC;
            phase_r       <= P_UNK;
            dwell_r       <= 4'd0;
            ovr_done_r    <= 1'b0;
            synced_r      <= 1'b0;
            err_illegal_r <= 1'b0;
            err_seq_r     <= 1'b0;
            err_timing_r  <= 1'b0;
            err_pulse_r   <= 1'b0;
            cycle_cnt_r   <= '0;
        end else begin
            state_r       <= state_s;
            phase_r       <= phase_s;
            dwell_r       <= dwell_s;
            ovr_done_r    <= ovr_done_s;
            synced_r      <= (state_s == TRACK);
            err_illegal_r <= det_illegal_s | (err_illegal_r & ~clr_err);
            err_seq_r     <= det_seq_s     | (err_seq_r     & ~clr_err);
            err_timing_r  <= det_timing_s  | (err_timing_r  & ~clr_err);
            err_pulse_r   <= det_illegal_s | det_seq_s | det_timing_s;
            if (cnt_inc_s) begin
                cycle_cnt_r <= cycle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
        end
    end

    assign phase       = phase_r;
    assign synced      = synced_r;
    assign err_illegal = err_illegal_r;
    assign err_seq     = err_seq_r;
    assign err_timing  = err_timing_r;
    assign err_pulse   = err_pulse_r;
    assign cycle_cnt   = cycle_cnt_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus a
// randomized phase schedule checked against an occupancy-level reference model.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [11:0] LAMPS [6] = '{ {G, G, R, R}, {G, Y, R, R}, {G, R, G, R},
                                           {Y, R, Y, R}, {R, R, R, G}, {R, R, R, Y} };
    localparam int DW [6] = '{8, 3, 6, 3, 4, 3};

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  M1, M2, MT, S;
    logic        clr_err;
    logic [2:0]  phase;
    logic        synced, err_illegal, err_seq, err_timing, err_pulse;
    logic [15:0] cycle_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: phase seen, whether locked on, occupancy length, flags.
    logic [2:0]  m_phase;
    bit          m_track, m_flag, m_ill, m_seq, m_tim, m_pulse;
    int          m_dwell;
    logic [15:0] m_cyc;

    traffic_light_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .M1          (M1),
        .M2          (M2),
        .MT          (MT),
        .S           (S),
        .clr_err     (clr_err),
        .phase       (phase),
        .synced      (synced),
        .err_illegal (err_illegal),
        .err_seq     (err_seq),
        .err_timing  (err_timing),
        .err_pulse   (err_pulse),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lookup(input logic [11:0] v);
        for (int i = 0; i < 6; i++) if (v == LAMPS[i]) return i;
        return -1;
    endfunction

    task automatic model_reset;
        m_phase = 3'd7; m_track = 0; m_flag = 0; m_dwell = 0;
        m_ill = 0; m_seq = 0; m_tim = 0; m_pulse = 0; m_cyc = 16'd0;
    endtask

    task automatic model_step(input logic [11:0] v, input logic clr);
        int p;
        bit ni, ns, nt;
        p = lookup(v); ni = 0; ns = 0; nt = 0;
        if (p < 0) begin
            ni = 1; m_phase = 3'd7; m_track = 0; m_dwell = 0;
        end else if (!m_track) begin
            if (m_phase == 3'd7) begin
                m_phase = 3'(p); m_dwell = 1;
            end else if (p == int'(m_phase)) begin
                m_dwell = (m_dwell < 15) ? m_dwell + 1 : 15;
            end else begin
                m_track = 1; m_phase = 3'(p); m_dwell = 1; m_flag = 0;
            end
        end else if (p == int'(m_phase)) begin
            if (m_dwell >= DW[m_phase] && !m_flag) begin nt = 1; m_flag = 1; end
            m_dwell = (m_dwell < 15) ? m_dwell + 1 : 15;
        end else begin
            if (p != (int'(m_phase) + 1) % 6) ns = 1;
            else if (m_dwell < DW[m_phase]) nt = 1;
            else if (m_phase == 3'd5) m_cyc = m_cyc + 16'd1;
            m_phase = 3'(p); m_dwell = 1; m_flag = 0;
        end
        m_ill   = ni || (m_ill && !clr);
        m_seq   = ns || (m_seq && !clr);
        m_tim   = nt || (m_tim && !clr);
        m_pulse = ni || ns || nt;
    endtask

    task automatic drive(input logic [11:0] v, input logic clr);
        {M1, M2, MT, S} = v;
        clr_err = clr;
        @(posedge clk);
        #1;
        model_step(v, clr);
    endtask

    task automatic hold(input int p, input int n, input logic clr_first);
        for (int i = 0; i < n; i++) drive(LAMPS[p], (i == 0) ? clr_first : 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1; clr_err = 1'b0; {M1, M2, MT, S} = {R, R, R, R};
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({phase, synced, err_illegal, err_seq, err_timing, err_pulse} !== {3'd7, 5'b0} || cycle_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: phase=%0d synced=%b errs=%b%b%b pulse=%b cnt=%0d, required phase=7 rest 0",
                     phase, synced, err_illegal, err_seq, err_timing, err_pulse, cycle_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_nominal;
        hold(0, 8, 1'b0);
        n_tests++;
        if (synced !== 1'b0 || phase !== 3'd0) begin
            n_fail++; $display("FAIL nominal_sync_p1: synced=%b phase=%0d, required 0/0", synced, phase);
        end
        hold(1, 1, 1'b0);
        n_tests++;
        if (synced !== 1'b1 || phase !== 3'd1) begin
            n_fail++; $display("FAIL nominal_lock: synced=%b phase=%0d, required 1/1", synced, phase);
        end
        hold(1, 2, 1'b0);
        for (int p = 2; p < 6; p++) hold(p, DW[p], 1'b0);
        for (int p = 0; p < 6; p++) hold(p, DW[p], 1'b0);
        hold(0, 1, 1'b0);
        n_tests++;
        if ({err_illegal, err_seq, err_timing, err_pulse} !== 4'b0 || cycle_cnt !== 16'd2 || phase !== 3'd0) begin
            n_fail++;
            $display("FAIL nominal_end: errs=%b%b%b pulse=%b cnt=%0d phase=%0d, required errs 0 cnt=2 phase=0",
                     err_illegal, err_seq, err_timing, err_pulse, cycle_cnt, phase);
        end
    endtask

    task automatic test_overrun;
        hold(0, 7, 1'b0);
        hold(1, 4, 1'b0);
        n_tests++;
        if (err_timing !== 1'b1 || err_pulse !== 1'b1) begin
            n_fail++; $display("FAIL overrun_flag: err_timing=%b err_pulse=%b, required 1/1", err_timing, err_pulse);
        end
        hold(1, 1, 1'b0);
        n_tests++;
        if (err_pulse !== 1'b0 || err_timing !== 1'b1) begin
            n_fail++; $display("FAIL overrun_single_pulse: err_pulse=%b err_timing=%b, required 0/1", err_pulse, err_timing);
        end
        hold(1, 1, 1'b1);
        n_tests++;
        if ({err_illegal, err_seq, err_timing, err_pulse} !== 4'b0) begin
            n_fail++; $display("FAIL overrun_clear: errs=%b%b%b pulse=%b, required 0000", err_illegal, err_seq, err_timing, err_pulse);
        end
    endtask

    task automatic test_underrun;
        hold(2, 5, 1'b0);
        n_tests++;
        if (err_timing !== 1'b0) begin
            n_fail++; $display("FAIL underrun_pre: err_timing=%b, required 0", err_timing);
        end
        hold(3, 1, 1'b0);
        n_tests++;
        if (err_timing !== 1'b1 || err_pulse !== 1'b1 || phase !== 3'd3 || err_seq !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun: err_timing=%b err_pulse=%b phase=%0d err_seq=%b, required 1/1/3/0",
                     err_timing, err_pulse, phase, err_seq);
        end
    endtask

    task automatic test_sequence;
        hold(3, 2, 1'b0);
        hold(4, 4, 1'b0);
        hold(5, 3, 1'b0);
        hold(0, 8, 1'b1);
        hold(2, 1, 1'b0);
        n_tests++;
        if (err_seq !== 1'b1 || err_timing !== 1'b0 || phase !== 3'd2 || synced !== 1'b1 || cycle_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL seq_skip: err_seq=%b err_timing=%b phase=%0d synced=%b cnt=%0d, required 1/0/2/1/3",
                     err_seq, err_timing, phase, synced, cycle_cnt);
        end
    endtask

    task automatic test_illegal;
        drive({3'b011, R, R, R}, 1'b1);
        n_tests++;
        if (err_illegal !== 1'b1 || err_seq !== 1'b0 || phase !== 3'd7 || synced !== 1'b0 || err_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal: err_illegal=%b err_seq=%b phase=%0d synced=%b pulse=%b, required 1/0/7/0/1",
                     err_illegal, err_seq, phase, synced, err_pulse);
        end
        hold(3, 1, 1'b0);
        n_tests++;
        if (phase !== 3'd3 || synced !== 1'b0) begin
            n_fail++; $display("FAIL resync_p4: phase=%0d synced=%b, required 3/0", phase, synced);
        end
        hold(4, 1, 1'b0);
        n_tests++;
        if (synced !== 1'b1 || err_seq !== 1'b0 || err_timing !== 1'b0 || phase !== 3'd4) begin
            n_fail++;
            $display("FAIL resync_p5: synced=%b err_seq=%b err_timing=%b phase=%0d, required 1/0/0/4",
                     synced, err_seq, err_timing, phase);
        end
    endtask

    task automatic test_clear_and_reset;
        hold(4, 1, 1'b1);
        hold(4, 2, 1'b0);
        n_tests++;
        if ({err_illegal, err_seq, err_timing} !== 3'b0) begin
            n_fail++; $display("FAIL clr_before_overrun: errs=%b%b%b, required 000", err_illegal, err_seq, err_timing);
        end
        hold(4, 1, 1'b1);
        n_tests++;
        if (err_timing !== 1'b1 || err_illegal !== 1'b0 || err_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_new: err_timing=%b err_illegal=%b pulse=%b, required 1/0/1", err_timing, err_illegal, err_pulse);
        end
        hold(4, 1, 1'b1);
        n_tests++;
        if ({err_illegal, err_seq, err_timing, err_pulse} !== 4'b0 || synced !== 1'b1 || phase !== 3'd4) begin
            n_fail++;
            $display("FAIL clr_alone: errs=%b%b%b pulse=%b synced=%b phase=%0d, required 0000/1/4",
                     err_illegal, err_seq, err_timing, err_pulse, synced, phase);
        end
        hold(5, 3, 1'b0);
        hold(0, 8, 1'b0);
        hold(1, 3, 1'b0);
        hold(2, 2, 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({phase, synced, err_illegal, err_seq, err_timing, err_pulse} !== {3'd7, 5'b0} || cycle_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset: phase=%0d synced=%b errs=%b%b%b pulse=%b cnt=%0d, required phase=7 rest 0",
                     phase, synced, err_illegal, err_seq, err_timing, err_pulse, cycle_cnt);
        end
    endtask

    task automatic test_random;
        int p, len, r;
        logic [23:0] got, exp;
        @(negedge clk) reset = 1'b1;
        p = $urandom_range(0, 5);
        for (int k = 0; k < 90; k++) begin
            r = $urandom_range(0, 19);
            len = DW[p];
            if (r == 1) len = len - 1;
            if (r == 2) len = len + 1;
            if (r == 3) len = len + 2;
            if (len < 1) len = 1;
            for (int i = -1; i < len; i++) begin
                if (i < 0 && r != 0) continue;
                drive((i < 0) ? 12'($urandom) : LAMPS[p], ($urandom_range(0, 9) == 0));
                got = {phase, synced, err_illegal, err_seq, err_timing, err_pulse, cycle_cnt};
                exp = {m_phase, m_track, m_ill, m_seq, m_tim, m_pulse, m_cyc};
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random[%0d.%0d]: got ph=%0d sy=%b e=%b%b%b pu=%b cnt=%0d, required ph=%0d sy=%b e=%b%b%b pu=%b cnt=%0d",
                             k, i, got[23:21], got[20], got[19], got[18], got[17], got[16], got[15:0],
                             exp[23:21], exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
                end
            end
            p = (r == 4) ? (p + 2) % 6 : (p + 1) % 6;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overrun();
        test_underrun();
        test_sequence();
        test_illegal();
        test_clear_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
